// File: rtl/fa_pkg.sv
// rtl/fa_pkg.sv - shared constants and result type for the fa ripple-carry adder
//
// Contents:
//   FA_MIN_WIDTH / FA_MAX_WIDTH : legal range of the fa WIDTH parameter
//   fa_result_t                 : {carry, sum} pair sized for the widest adder
package fa_pkg;

  localparam int FA_MIN_WIDTH = 1;
  localparam int FA_MAX_WIDTH = 64;

  // Narrower adders use the low WIDTH bits of sum; the upper bits stay zero.
  typedef struct packed {
    logic                    carry;
    logic [FA_MAX_WIDTH-1:0] sum;
  } fa_result_t;

endpackage

// File: rtl/fa_bit.sv
// rtl/fa_bit.sv - purely combinational 1-bit full-adder cell
//
// Ports:
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit,   a ^ b ^ cin
//   cout : carry out, majority(a, b, cin)
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa.sv
// rtl/fa.sv - WIDTH-bit ripple-carry adder with one output register stage
//
// Optional feature macro: FA_OVERFLOW_EN (adds the registered overflow output)
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : capture enable for the operands below
//   a, b      : WIDTH-bit unsigned operands
//   carry_in  : carry into bit 0
//   sum       : registered (a + b + carry_in) mod 2^WIDTH
//   carry_out : registered carry out of the top bit
//   out_valid : sum/carry_out were captured on the previous edge
//   overflow  : registered two's-complement overflow (FA_OVERFLOW_EN only)
module fa
  import fa_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid
`ifdef FA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  if (WIDTH < FA_MIN_WIDTH || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $error("fa: WIDTH %0d outside supported range", WIDTH);
  end

  // w_carry[i] is the carry into bit i; w_carry[WIDTH] leaves the top cell.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_valid;

  assign w_carry[0] = carry_in;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    fa_bit u_bit (
      .a    (a[g]),
      .b    (b[g]),
      .cin  (w_carry[g]),
      .s    (w_sum[g]),
      .cout (w_carry[g+1])
    );
  end

  // Result registers load only on a valid input; out_valid is a per-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry[WIDTH];
      end
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry;
  assign out_valid = r_valid;

`ifdef FA_OVERFLOW_EN
  logic r_overflow;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  // For WIDTH=1 the carry into the sign bit is carry_in itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (in_valid) begin
      r_overflow <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
    end
  end

  assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_fa.sv
// tb/tb_fa.sv - self-checking bench for fa at WIDTH 1, 8 and 16
module tb_fa;
  import fa_pkg::*;

  logic clk;
  logic rst_n;

  logic        v1,  c1,  s1,  co1, vo1;
  logic        a1,  b1;
  logic        v8,  c8,  co8, vo8;
  logic [7:0]  a8,  b8,  s8;
  logic        v16, c16, co16, vo16;
  logic [15:0] a16, b16, s16;
`ifdef FA_OVERFLOW_EN
  logic        of1, of8, of16;
`endif

  int checks   = 0;
  int failures = 0;

  fa #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .carry_in(c1),
    .sum(s1), .carry_out(co1), .out_valid(vo1)
`ifdef FA_OVERFLOW_EN
    , .overflow(of1)
`endif
  );

  fa #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .carry_in(c8),
    .sum(s8), .carry_out(co8), .out_valid(vo8)
`ifdef FA_OVERFLOW_EN
    , .overflow(of8)
`endif
  );

  fa #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .carry_in(c16),
    .sum(s16), .carry_out(co16), .out_valid(vo16)
`ifdef FA_OVERFLOW_EN
    , .overflow(of16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  tt [8];
    logic [2:0]  idx;
    fa_result_t  e, o;
    logic        ev;
    logic        eo;
    int          nvalid;
    int          ssum;
    logic [7:0]  bb_a [3];
    logic [7:0]  bb_b [3];
    logic        bb_c [3];
    logic [8:0]  bb_r [3];

    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    bb_a = '{8'h10, 8'h80, 8'h7F};
    bb_b = '{8'h20, 8'h80, 8'h00};
    bb_c = '{1'b0, 1'b1, 1'b1};
    bb_r = '{9'h030, 9'h101, 9'h080};

    rst_n = 1'b0;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    v16 = 0; a16 = 0; b16 = 0; c16 = 0;

    // Reset state
    #3;
    chk("reset_w1",  {63'd0, vo1, co1, s1}, 66'd0);
    chk("reset_w8",  {56'd0, vo8, co8, s8}, 66'd0);
    chk("reset_w16", {48'd0, vo16, co16, s16}, 66'd0);
`ifdef FA_OVERFLOW_EN
    chk("reset_of", {63'd0, of1, of8, of16}, 66'd0);
`endif
    #4 rst_n = 1'b1;

    // WIDTH=1 truth table, one cycle latency
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      v1 = 1; a1 = idx[2]; b1 = idx[1]; c1 = idx[0];
      tick();
      chk($sformatf("truth_%0d", i), {63'd0, vo1, co1, s1}, {63'd0, 1'b1, tt[i]});
`ifdef FA_OVERFLOW_EN
      chk($sformatf("truth_of_%0d", i), {65'd0, of1}, {65'd0, tt[i][1] ^ idx[0]});
`endif
    end

    // Asynchronous reset mid-operation
    a1 = 1; b1 = 1; c1 = 1; v1 = 1;
    tick();
    chk("pre_reset", {63'd0, vo1, co1, s1}, {63'd0, 3'b111});
    v1 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {63'd0, vo1, co1, s1}, 66'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_reset_idle1", {63'd0, vo1, co1, s1}, 66'd0);
    tick();
    chk("post_reset_idle2", {63'd0, vo1, co1, s1}, 66'd0);
    v1 = 1; a1 = 1; b1 = 0; c1 = 0;
    tick();
    chk("first_after_reset", {63'd0, vo1, co1, s1}, {63'd0, 3'b101});
    v1 = 0;

    // WIDTH=8 wrap then hold for 3 idle cycles
    v8 = 1; a8 = 8'hFF; b8 = 8'h01; c8 = 0;
    tick();
    chk("wrap", {56'd0, vo8, co8, s8}, {56'd0, 1'b1, 1'b1, 8'h00});
    for (int i = 0; i < 3; i++) begin
      v8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      tick();
      chk($sformatf("hold_%0d", i), {56'd0, vo8, co8, s8}, {56'd0, 1'b0, 1'b1, 8'h00});
    end

    // Back-to-back valid inputs
    for (int i = 0; i < 3; i++) begin
      v8 = 1; a8 = bb_a[i]; b8 = bb_b[i]; c8 = bb_c[i];
      tick();
      chk($sformatf("b2b_%0d", i), {56'd0, vo8, co8, s8}, {56'd0, 1'b1, bb_r[i]});
    end
    v8 = 0;

`ifdef FA_OVERFLOW_EN
    v8 = 1; a8 = 8'h7F; b8 = 8'h01; c8 = 0;
    tick();
    chk("ovf_7f_01", {56'd0, of8, co8, s8}, {56'd0, 1'b1, 1'b0, 8'h80});
    a8 = 8'h80; b8 = 8'hFF; c8 = 0;
    tick();
    chk("ovf_80_ff", {56'd0, of8, co8, s8}, {56'd0, 1'b1, 1'b1, 8'h7F});
    a8 = 8'h05; b8 = 8'hFB; c8 = 0;
    tick();
    chk("ovf_05_fb", {56'd0, of8, co8, s8}, {56'd0, 1'b0, 1'b1, 8'h00});
    v8 = 0;
`endif

    // Random WIDTH=16 against an arithmetic reference
    e = '0; ev = 1'b0; eo = 1'b0; nvalid = 0;
    while (nvalid < 10000) begin
      v16 = ($urandom_range(7) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      if (v16) begin
        logic [16:0] full;
        full = {1'b0, a16} + {1'b0, b16} + {16'd0, c16};
        e = '0;
        e.carry = full[16];
        e.sum[15:0] = full[15:0];
        ssum = int'($signed(a16)) + int'($signed(b16)) + int'(c16);
        eo = (ssum > 32767) || (ssum < -32768);
        ev = 1'b1;
        nvalid++;
      end else begin
        ev = 1'b0;
      end
      tick();
      o = '0;
      o.carry = co16;
      o.sum[15:0] = s16;
      chk("rand16", {vo16, o}, {ev, e});
`ifdef FA_OVERFLOW_EN
      chk("rand16_of", {65'd0, of16}, {65'd0, eo});
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
